// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared types and default depths for the lane operand queues
// Purpose: common typedefs used by operand_queue_channel and operand_queue_array.
package ara_pkg;

    localparam int unsigned OpqDefaultDataDepth = 2;
    localparam int unsigned OpqDefaultCmdDepth  = 4;
    localparam int unsigned OpqCntWidth         = 16;

    // Per-instruction element count.
    typedef logic [OpqCntWidth-1:0] opq_cnt_t;

    // Sticky error flags of one channel.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } opq_err_t;

endpackage

// File: rtl/operand_queue_channel.sv
// rtl/operand_queue_channel.sv - one operand channel: data FIFO, command FIFO, credits, element counter
// Ports:
//   clk_i, rst_i (async, active high), flush_i (synchronous, keeps error flags)
//   cmd_i/cmd_valid_i/cmd_ready_o          : per-instruction element counts
//   operand_issued_i/operand_queue_ready_o : credit reservation toward the requester
//   operand_i/operand_valid_i              : VRF read data in
//   operand_o/operand_last_o/operand_valid_o/operand_ready_i : data out to the VFU
//   err_o                                  : sticky overflow/underflow flags
module operand_queue_channel
    import ara_pkg::*;
#(
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned DataBufDepth = OpqDefaultDataDepth,
    parameter int unsigned CmdBufDepth  = OpqDefaultCmdDepth,
    parameter int unsigned CntWidth     = OpqCntWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [CntWidth-1:0]  cmd_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 operand_issued_i,
    output logic                 operand_queue_ready_o,
    input  logic [DataWidth-1:0] operand_i,
    input  logic                 operand_valid_i,
    output logic [DataWidth-1:0] operand_o,
    output logic                 operand_last_o,
    output logic                 operand_valid_o,
    input  logic                 operand_ready_i,
    output opq_err_t             err_o
);

    localparam int unsigned DPtrW = (DataBufDepth > 1) ? $clog2(DataBufDepth) : 1;
    localparam int unsigned DCntW = $clog2(DataBufDepth + 1);
    localparam int unsigned CPtrW = (CmdBufDepth > 1) ? $clog2(CmdBufDepth) : 1;
    localparam int unsigned CCntW = $clog2(CmdBufDepth + 1);

    logic [DataWidth-1:0] dmem_q [DataBufDepth];
    logic [DataWidth-1:0] dmem_d [DataBufDepth];
    logic [DPtrW-1:0]     drd_q, drd_d, dwr_q, dwr_d;
    logic [DCntW-1:0]     dcnt_q, dcnt_d;
    logic [DCntW-1:0]     credit_q, credit_d;

    logic [CntWidth-1:0]  cmem_q [CmdBufDepth];
    logic [CntWidth-1:0]  cmem_d [CmdBufDepth];
    logic [CPtrW-1:0]     crd_q, crd_d, cwr_q, cwr_d;
    logic [CCntW-1:0]     ccnt_q, ccnt_d;

    logic [CntWidth-1:0]  elem_q, elem_d;
    opq_err_t             err_q, err_d;

    logic d_empty, d_full, c_empty, c_full;
    logic valid, last, pop, push_ok, cmd_push, cmd_pop;
    logic [CntWidth-1:0] head_cnt;

    assign d_empty  = (dcnt_q == '0);
    assign d_full   = (dcnt_q == DCntW'(DataBufDepth));
    assign c_empty  = (ccnt_q == '0);
    assign c_full   = (ccnt_q == CCntW'(CmdBufDepth));
    assign head_cnt = cmem_q[crd_q];

    // Data is only released once an instruction is known to own it.
    assign valid    = !d_empty && !c_empty;
    // Head counts are never zero (zero counts are dropped at push).
    assign last     = valid && (elem_q == head_cnt - CntWidth'(1));
    assign pop      = valid && operand_ready_i;
    // A same-cycle pop frees the slot, so writing into a full FIFO is then legal.
    assign push_ok  = operand_valid_i && (!d_full || pop);
    assign cmd_push = cmd_valid_i && !c_full && (cmd_i != '0);
    assign cmd_pop  = pop && last;

    always_comb begin
        dmem_d   = dmem_q;
        drd_d    = drd_q;
        dwr_d    = dwr_q;
        dcnt_d   = dcnt_q;
        credit_d = credit_q;
        cmem_d   = cmem_q;
        crd_d    = crd_q;
        cwr_d    = cwr_q;
        ccnt_d   = ccnt_q;
        elem_d   = elem_q;
        err_d    = err_q;

        if (pop) begin
            drd_d = (drd_q == DPtrW'(DataBufDepth - 1)) ? '0 : drd_q + DPtrW'(1);
        end
        if (push_ok) begin
            dmem_d[dwr_q] = operand_i;
            dwr_d = (dwr_q == DPtrW'(DataBufDepth - 1)) ? '0 : dwr_q + DPtrW'(1);
        end
        if (push_ok && !pop) begin
            dcnt_d = dcnt_q + DCntW'(1);
        end else if (!push_ok && pop) begin
            dcnt_d = dcnt_q - DCntW'(1);
        end
        if (operand_valid_i && d_full && !pop) begin
            err_d.overflow = 1'b1;
        end

        // Issue+pop cancel; an issue matched by a pop is never an underflow.
        case ({operand_issued_i, pop})
            2'b10: begin
                if (credit_q != '0) begin
                    credit_d = credit_q - DCntW'(1);
                end else begin
                    err_d.underflow = 1'b1;
                end
            end
            2'b01: begin
                if (credit_q != DCntW'(DataBufDepth)) begin
                    credit_d = credit_q + DCntW'(1);
                end
            end
            default: ;
        endcase

        if (cmd_push) begin
            cmem_d[cwr_q] = cmd_i;
            cwr_d = (cwr_q == CPtrW'(CmdBufDepth - 1)) ? '0 : cwr_q + CPtrW'(1);
        end
        if (cmd_pop) begin
            crd_d = (crd_q == CPtrW'(CmdBufDepth - 1)) ? '0 : crd_q + CPtrW'(1);
        end
        if (cmd_push && !cmd_pop) begin
            ccnt_d = ccnt_q + CCntW'(1);
        end else if (!cmd_push && cmd_pop) begin
            ccnt_d = ccnt_q - CCntW'(1);
        end

        if (pop) begin
            elem_d = last ? '0 : elem_q + CntWidth'(1);
        end

        // Flush overrides all same-cycle activity; error flags survive it.
        if (flush_i) begin
            drd_d    = '0;
            dwr_d    = '0;
            dcnt_d   = '0;
            credit_d = DCntW'(DataBufDepth);
            crd_d    = '0;
            cwr_d    = '0;
            ccnt_d   = '0;
            elem_d   = '0;
            err_d    = err_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dmem_q   <= '{default: '0};
            drd_q    <= '0;
            dwr_q    <= '0;
            dcnt_q   <= '0;
            credit_q <= DCntW'(DataBufDepth);
            cmem_q   <= '{default: '0};
            crd_q    <= '0;
            cwr_q    <= '0;
            ccnt_q   <= '0;
            elem_q   <= '0;
            err_q    <= '0;
        end else begin
            dmem_q   <= dmem_d;
            drd_q    <= drd_d;
            dwr_q    <= dwr_d;
            dcnt_q   <= dcnt_d;
            credit_q <= credit_d;
            cmem_q   <= cmem_d;
            crd_q    <= crd_d;
            cwr_q    <= cwr_d;
            ccnt_q   <= ccnt_d;
            elem_q   <= elem_d;
            err_q    <= err_d;
        end
    end

    assign operand_o             = d_empty ? '0 : dmem_q[drd_q];
    assign operand_valid_o       = valid;
    assign operand_last_o        = last;
    assign operand_queue_ready_o = (credit_q != '0);
    assign cmd_ready_o           = !c_full;
    assign err_o                 = err_q;

endmodule

// File: rtl/operand_queue_array.sv
// rtl/operand_queue_array.sv - NrQueues independent operand channels with packed port vectors
// Ports (all per channel, packed NrQueues-wide; channel g uses slice g):
//   clk_i, rst_i (async, active high), flush_i
//   cmd_i/cmd_valid_i/cmd_ready_o, operand_issued_i/operand_queue_ready_o
//   operand_i/operand_valid_i, operand_o/operand_last_o/operand_valid_o/operand_ready_i
//   err_overflow_o/err_underflow_o (sticky)
module operand_queue_array
    import ara_pkg::*;
#(
    parameter int unsigned NrQueues     = 4,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned DataBufDepth = OpqDefaultDataDepth,
    parameter int unsigned CmdBufDepth  = OpqDefaultCmdDepth,
    parameter int unsigned CntWidth     = OpqCntWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NrQueues-1:0]           flush_i,
    input  logic [NrQueues*CntWidth-1:0]  cmd_i,
    input  logic [NrQueues-1:0]           cmd_valid_i,
    output logic [NrQueues-1:0]           cmd_ready_o,
    input  logic [NrQueues-1:0]           operand_issued_i,
    output logic [NrQueues-1:0]           operand_queue_ready_o,
    input  logic [NrQueues*DataWidth-1:0] operand_i,
    input  logic [NrQueues-1:0]           operand_valid_i,
    output logic [NrQueues*DataWidth-1:0] operand_o,
    output logic [NrQueues-1:0]           operand_last_o,
    output logic [NrQueues-1:0]           operand_valid_o,
    input  logic [NrQueues-1:0]           operand_ready_i,
    output logic [NrQueues-1:0]           err_overflow_o,
    output logic [NrQueues-1:0]           err_underflow_o
);

    for (genvar g = 0; g < NrQueues; g++) begin : gen_ch
        opq_err_t ch_err;

        operand_queue_channel #(
            .DataWidth   (DataWidth),
            .DataBufDepth(DataBufDepth),
            .CmdBufDepth (CmdBufDepth),
            .CntWidth    (CntWidth)
        ) u_ch (
            .clk_i                (clk_i),
            .rst_i                (rst_i),
            .flush_i              (flush_i[g]),
            .cmd_i                (cmd_i[g*CntWidth +: CntWidth]),
            .cmd_valid_i          (cmd_valid_i[g]),
            .cmd_ready_o          (cmd_ready_o[g]),
            .operand_issued_i     (operand_issued_i[g]),
            .operand_queue_ready_o(operand_queue_ready_o[g]),
            .operand_i            (operand_i[g*DataWidth +: DataWidth]),
            .operand_valid_i      (operand_valid_i[g]),
            .operand_o            (operand_o[g*DataWidth +: DataWidth]),
            .operand_last_o       (operand_last_o[g]),
            .operand_valid_o      (operand_valid_o[g]),
            .operand_ready_i      (operand_ready_i[g]),
            .err_o                (ch_err)
        );

        assign err_overflow_o[g]  = ch_err.overflow;
        assign err_underflow_o[g] = ch_err.underflow;
    end

endmodule

// File: tb/tb_operand_queue_array.sv
// tb/tb_operand_queue_array.sv - directed self-checking bench for operand_queue_array
module tb_operand_queue_array;
    import ara_pkg::*;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NQ-1:0]    flush, cmd_valid, cmd_ready, issued, q_ready;
    logic [NQ-1:0]    op_valid_in, op_last, op_valid, op_ready, err_ov, err_un;
    logic [NQ*CW-1:0] cmd;
    logic [NQ*DW-1:0] op_in, op_out;

    logic             f3, cmd3_v, cmd3_rdy, iss3, qrdy3, inv3, last3, vout3, rdy3, ov3, un3;
    opq_cnt_t         cmd3;
    logic [DW-1:0]    in3, out3;

    operand_queue_array #(
        .NrQueues(NQ), .DataWidth(DW), .DataBufDepth(2), .CmdBufDepth(4), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .cmd_i(cmd), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .operand_issued_i(issued), .operand_queue_ready_o(q_ready),
        .operand_i(op_in), .operand_valid_i(op_valid_in),
        .operand_o(op_out), .operand_last_o(op_last), .operand_valid_o(op_valid),
        .operand_ready_i(op_ready),
        .err_overflow_o(err_ov), .err_underflow_o(err_un)
    );

    operand_queue_array #(
        .NrQueues(1), .DataWidth(DW), .DataBufDepth(3), .CmdBufDepth(4), .CntWidth(CW)
    ) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(f3),
        .cmd_i(cmd3), .cmd_valid_i(cmd3_v), .cmd_ready_o(cmd3_rdy),
        .operand_issued_i(iss3), .operand_queue_ready_o(qrdy3),
        .operand_i(in3), .operand_valid_i(inv3),
        .operand_o(out3), .operand_last_o(last3), .operand_valid_o(vout3),
        .operand_ready_i(rdy3),
        .err_overflow_o(ov3), .err_underflow_o(un3)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush = '0; cmd_valid = '0; issued = '0; op_valid_in = '0; op_ready = '0;
        cmd = '0; op_in = '0;
        f3 = 1'b0; cmd3_v = 1'b0; iss3 = 1'b0; inv3 = 1'b0; rdy3 = 1'b0;
        cmd3 = '0; in3 = '0;
    endtask

    int sent;
    int recv;
    logic rdy;

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Traffic on every channel, then an asynchronous reset in the middle of it.
        cmd_valid = '1; cmd = {NQ{16'd2}}; op_valid_in = '1; issued = '1;
        op_in = {NQ{64'h55}};
        tick();
        idle_inputs();
        check_vec("pre_rst_valid", 64'(op_valid), 64'hF);
        rst = 1'b1;
        #1;
        check_vec("rst_valid", 64'(op_valid), 64'h0);
        check_vec("rst_last", 64'(op_last), 64'h0);
        check_vec("rst_qready", 64'(q_ready), 64'hF);
        check_vec("rst_cmdready", 64'(cmd_ready), 64'hF);
        for (int c = 0; c < NQ; c++) check_vec("rst_operand", op_out[c*DW +: DW], 64'h0);
        tick();
        rst = 1'b0;
        tick();
        check_vec("post_rst_valid", 64'(op_valid), 64'h0);
        check_vec("post_rst_qready", 64'(q_ready), 64'hF);
        check_vec("post_rst_err", 64'({err_ov, err_un}), 64'h0);

        // Channel 0: cmd=3, three issue+write pairs, consumer always ready.
        cmd_valid[0] = 1'b1; cmd[0 +: CW] = 16'd3; issued[0] = 1'b1;
        op_valid_in[0] = 1'b1; op_in[0 +: DW] = 64'hA; op_ready[0] = 1'b1;
        tick();
        cmd_valid[0] = 1'b0; op_in[0 +: DW] = 64'hB;
        check_vec("c0_w0_valid", 64'(op_valid[0]), 64'h1);
        check_vec("c0_w0_data", op_out[0 +: DW], 64'hA);
        check_vec("c0_w0_last", 64'(op_last[0]), 64'h0);
        tick();
        op_in[0 +: DW] = 64'hC;
        check_vec("c0_w1_data", op_out[0 +: DW], 64'hB);
        check_vec("c0_w1_last", 64'(op_last[0]), 64'h0);
        tick();
        issued[0] = 1'b0; op_valid_in[0] = 1'b0;
        check_vec("c0_w2_valid", 64'(op_valid[0]), 64'h1);
        check_vec("c0_w2_data", op_out[0 +: DW], 64'hC);
        check_vec("c0_w2_last", 64'(op_last[0]), 64'h1);
        tick();
        check_vec("c0_drained", 64'(op_valid[0]), 64'h0);
        check_vec("c0_drained_data", op_out[0 +: DW], 64'h0);
        // Data with no command behind it must stay hidden.
        op_valid_in[0] = 1'b1; op_in[0 +: DW] = 64'hD;
        tick();
        op_valid_in[0] = 1'b0;
        check_vec("c0_nocmd_gate", 64'(op_valid[0]), 64'h0);
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0; op_ready[0] = 1'b0;

        // Channel 0: credit stall and underflow.
        issued[0] = 1'b1;
        tick();
        check_vec("c0_cred1_ready", 64'(q_ready[0]), 64'h1);
        tick();
        check_vec("c0_cred0_ready", 64'(q_ready[0]), 64'h0);
        check_vec("c0_no_uf_yet", 64'(err_un[0]), 64'h0);
        tick();
        issued[0] = 1'b0;
        check_vec("c0_underflow", 64'(err_un[0]), 64'h1);
        check_vec("c0_uf_cred_held", 64'(q_ready[0]), 64'h0);
        cmd_valid[0] = 1'b1; cmd[0 +: CW] = 16'd1;
        op_valid_in[0] = 1'b1; op_in[0 +: DW] = 64'hE; op_ready[0] = 1'b1;
        tick();
        cmd_valid[0] = 1'b0; op_valid_in[0] = 1'b0;
        check_vec("c0_e_last", 64'(op_last[0]), 64'h1);
        tick();
        op_ready[0] = 1'b0;
        check_vec("c0_pop_credit", 64'(q_ready[0]), 64'h1);
        check_vec("c0_pop_valid", 64'(op_valid[0]), 64'h0);
        check_vec("other_uf_clear", 64'(err_un[3:1]), 64'h0);

        // Channel 2: back-to-back commands of 1 and 2 elements.
        cmd_valid[2] = 1'b1; cmd[2*CW +: CW] = 16'd1; issued[2] = 1'b1;
        op_valid_in[2] = 1'b1; op_in[2*DW +: DW] = 64'h20;
        tick();
        cmd[2*CW +: CW] = 16'd2; op_in[2*DW +: DW] = 64'h21; op_ready[2] = 1'b1;
        check_vec("c2_w0_data", op_out[2*DW +: DW], 64'h20);
        check_vec("c2_w0_last", 64'(op_last[2]), 64'h1);
        tick();
        cmd_valid[2] = 1'b0; op_in[2*DW +: DW] = 64'h22;
        check_vec("c2_nobubble", 64'(op_valid[2]), 64'h1);
        check_vec("c2_w1_data", op_out[2*DW +: DW], 64'h21);
        check_vec("c2_w1_last", 64'(op_last[2]), 64'h0);
        tick();
        issued[2] = 1'b0; op_valid_in[2] = 1'b0;
        check_vec("c2_w2_data", op_out[2*DW +: DW], 64'h22);
        check_vec("c2_w2_last", 64'(op_last[2]), 64'h1);
        tick();
        op_ready[2] = 1'b0;
        check_vec("c2_drained", 64'(op_valid[2]), 64'h0);

        // Channel 1: fill, overflow, then flush with a same-cycle write/pop/issue.
        cmd_valid[1] = 1'b1; cmd[CW +: CW] = 16'd5; issued[1] = 1'b1;
        op_valid_in[1] = 1'b1; op_in[DW +: DW] = 64'h30;
        tick();
        cmd_valid[1] = 1'b0; op_in[DW +: DW] = 64'h31;
        tick();
        issued[1] = 1'b0; op_in[DW +: DW] = 64'h32;
        tick();
        op_valid_in[1] = 1'b0;
        check_vec("c1_overflow", 64'(err_ov[1]), 64'h1);
        check_vec("c1_head_kept", op_out[DW +: DW], 64'h30);
        flush[1] = 1'b1; op_valid_in[1] = 1'b1; op_in[DW +: DW] = 64'h33;
        op_ready[1] = 1'b1; issued[1] = 1'b1;
        cmd_valid[3] = 1'b1; cmd[3*CW +: CW] = 16'd1; issued[3] = 1'b1;
        op_valid_in[3] = 1'b1; op_in[3*DW +: DW] = 64'h40;
        tick();
        idle_inputs();
        check_vec("c1_flush_valid", 64'(op_valid[1]), 64'h0);
        check_vec("c1_flush_data", op_out[DW +: DW], 64'h0);
        check_vec("c1_flush_ov_kept", 64'(err_ov[1]), 64'h1);
        check_vec("c0_uf_kept", 64'(err_un[0]), 64'h1);
        check_vec("c3_valid", 64'(op_valid[3]), 64'h1);
        check_vec("c3_data", op_out[3*DW +: DW], 64'h40);
        check_vec("c3_last", 64'(op_last[3]), 64'h1);
        issued[1] = 1'b1;
        tick();
        check_vec("c1_flush_cred1", 64'(q_ready[1]), 64'h1);
        tick();
        issued[1] = 1'b0;
        check_vec("c1_flush_cred0", 64'(q_ready[1]), 64'h0);
        check_vec("c1_no_uf", 64'(err_un[1]), 64'h0);
        op_ready[3] = 1'b1;
        tick();
        op_ready[3] = 1'b0; flush[1] = 1'b1;
        check_vec("c3_drained", 64'(op_valid[3]), 64'h0);
        tick();
        flush[1] = 1'b0;

        // Depth-3 instance: cmd=0 is discarded, then ten words streamed across the wrap.
        cmd3_v = 1'b1; cmd3 = 16'd0; iss3 = 1'b1; inv3 = 1'b1; in3 = 64'h100;
        tick();
        cmd3_v = 1'b0; iss3 = 1'b0; inv3 = 1'b0;
        check_vec("d3_cmd0_discard", 64'(vout3), 64'h0);
        check_vec("d3_cmd0_ready", 64'(cmd3_rdy), 64'h1);
        sent = 1;
        recv = 0;
        cmd3_v = 1'b1; cmd3 = 16'd10;
        tick();
        cmd3_v = 1'b0;
        for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            if (vout3 && rdy) begin
                check_vec("d3_stream_data", out3, 64'h100 + 64'(recv));
                check_vec("d3_stream_last", 64'(last3), 64'(recv == 9));
                recv++;
            end
            rdy3 = rdy;
            if (qrdy3 && sent < 10) begin
                iss3 = 1'b1; inv3 = 1'b1; in3 = 64'h100 + 64'(sent);
                sent++;
            end else begin
                iss3 = 1'b0; inv3 = 1'b0;
            end
            tick();
        end
        iss3 = 1'b0; inv3 = 1'b0; rdy3 = 1'b0;
        check_vec("d3_stream_count", 64'(recv), 64'd10);
        check_vec("d3_no_overflow", 64'(ov3), 64'h0);
        check_vec("d3_no_underflow", 64'(un3), 64'h0);
        check_vec("d3_end_valid", 64'(vout3), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
